id_ex_stage: RTL and testbench

ID/EX pipeline stage sitting directly upstream of the ALU. It registers the decoded instruction each cycle and resolves operand forwarding from the MEM and WB stages. It detects load-use hazards and stalls decode for one cycle, inserting a bubble. Its outputs `val1`, `val2` and `exe_cmd` drive the ALU operand and command inputs directly.

---
 rtl/exe_pkg.sv | 20 ++
 rtl/fwd_mux.sv | 38 +++
 rtl/id_ex_stage.sv | 192 +++++++++++++++++++
 tb/tb_id_ex_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_pkg.sv
// Shared execute-stage definitions: ALU command encoding and register constants.
package exe_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    AND = 4'd2,
    OR  = 4'd3,
    NOR = 4'd4,
    XOR = 4'd5,
    SLA = 4'd6,
    SLL = 4'd7,
    SRA = 4'd8,
    SRL = 4'd9
  } execmd_t;

  // Architectural zero register: never written, never forwarded.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/fwd_mux.sv
// Three-way priority operand selector: MEM producer, then WB producer, then
// the value captured from the register file. x0 is never forwarded.
module fwd_mux
  import exe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic [RIDX-1:0] i_src,
  input  logic [XLEN-1:0] i_reg_val,
  input  logic            i_mem_en,
  input  logic [RIDX-1:0] i_mem_rd,
  input  logic [XLEN-1:0] i_mem_val,
  input  logic            i_wb_en,
  input  logic [RIDX-1:0] i_wb_rd,
  input  logic [XLEN-1:0] i_wb_val,
  output logic [XLEN-1:0] o_val
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_en && (i_mem_rd != RIDX'(REG_ZERO)) && (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_en  && (i_wb_rd  != RIDX'(REG_ZERO)) && (i_wb_rd  == i_src);

  // Pick the youngest producer of the source register, MEM before WB.
  always_comb begin
    o_val = i_reg_val;
    if (w_mem_hit) begin
      o_val = i_mem_val;
    end else if (w_wb_hit) begin
      o_val = i_wb_val;
    end else begin
      o_val = i_reg_val;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Captures the decoded instruction,
// forwards operands from MEM/WB and stalls decode on load-use hazards.
// Optional feature macro: ID_EX_FWD_EN (defined = MEM/WB forwarding muxes;
// undefined = no forwarding, decode stalls on any RAW match in EX/MEM/WB).
module id_ex_stage
  import exe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  execmd_t         id_exe_cmd,
  input  logic [RIDX-1:0] id_rs1,
  input  logic [RIDX-1:0] id_rs2,
  input  logic [RIDX-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_val,
  input  logic [XLEN-1:0] id_rs2_val,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_wb_en,
  input  logic            mem_wb_en,
  input  logic [RIDX-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_wb_en,
  input  logic [RIDX-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output execmd_t         exe_cmd,
  output logic [XLEN-1:0] val1,
  output logic [XLEN-1:0] val2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RIDX-1:0] ex_rd,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_wb_en,
  output logic [31:0]     stall_cnt
);

  // Pipeline registers
  logic            r_valid;
  execmd_t         r_cmd;
  logic [RIDX-1:0] r_rd;
  logic [XLEN-1:0] r_rs1_val;
  logic [XLEN-1:0] r_rs2_val;
  logic [XLEN-1:0] r_imm;
  logic            r_use_imm;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_wb_en;
  logic [31:0]     r_stall_cnt;
`ifdef ID_EX_FWD_EN
  logic [RIDX-1:0] r_rs1;
  logic [RIDX-1:0] r_rs2;
`endif

  logic            w_load_use;
  logic            w_hz;
  logic [XLEN-1:0] w_fwd_rs1;
  logic [XLEN-1:0] w_fwd_rs2;

  // True when producer register rd (non-zero) feeds an operand the decode
  // instruction actually reads: rs1 always, rs2 for reg-reg ops and stores.
  function automatic logic src_hit(
    input logic [RIDX-1:0] rd,
    input logic [RIDX-1:0] rs1,
    input logic [RIDX-1:0] rs2,
    input logic            use_imm,
    input logic            mem_write
  );
    src_hit = (rd != RIDX'(REG_ZERO)) &&
              ((rs1 == rd) || (!use_imm && (rs2 == rd)) || (mem_write && (rs2 == rd)));
  endfunction

  assign w_load_use = r_valid && r_mem_read && id_valid &&
                      src_hit(r_rd, id_rs1, id_rs2, id_use_imm, id_mem_write);

`ifdef ID_EX_FWD_EN
  assign w_hz = w_load_use;
`else
  // Without forwarding every in-flight producer blocks its consumers.
  assign w_hz = w_load_use ||
                (id_valid && ((r_valid && r_wb_en &&
                               src_hit(r_rd, id_rs1, id_rs2, id_use_imm, id_mem_write)) ||
                              (mem_wb_en &&
                               src_hit(mem_rd, id_rs1, id_rs2, id_use_imm, id_mem_write)) ||
                              (wb_wb_en &&
                               src_hit(wb_rd, id_rs1, id_rs2, id_use_imm, id_mem_write))));
`endif

  assign id_ready = ~w_hz;

  // Capture decode each cycle; a hazard loads a bubble, flush kills the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_cmd       <= ADD;
      r_rd        <= '0;
      r_rs1_val   <= '0;
      r_rs2_val   <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_wb_en     <= 1'b0;
`ifdef ID_EX_FWD_EN
      r_rs1       <= '0;
      r_rs2       <= '0;
`endif
    end else if (w_hz) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_wb_en     <= 1'b0;
    end else begin
      r_valid     <= id_valid & ~flush;
      r_cmd       <= id_exe_cmd;
      r_rd        <= id_rd;
      r_rs1_val   <= id_rs1_val;
      r_rs2_val   <= id_rs2_val;
      r_imm       <= id_imm;
      r_use_imm   <= id_use_imm;
      r_mem_read  <= id_mem_read;
      r_mem_write <= id_mem_write;
      r_wb_en     <= id_wb_en;
`ifdef ID_EX_FWD_EN
      r_rs1       <= id_rs1;
      r_rs2       <= id_rs2;
`endif
    end
  end

  // Count stall cycles, saturating; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (w_hz && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

`ifdef ID_EX_FWD_EN
  fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_rs1 (
    .i_src     (r_rs1),
    .i_reg_val (r_rs1_val),
    .i_mem_en  (mem_wb_en),
    .i_mem_rd  (mem_rd),
    .i_mem_val (mem_result),
    .i_wb_en   (wb_wb_en),
    .i_wb_rd   (wb_rd),
    .i_wb_val  (wb_result),
    .o_val     (w_fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_rs2 (
    .i_src     (r_rs2),
    .i_reg_val (r_rs2_val),
    .i_mem_en  (mem_wb_en),
    .i_mem_rd  (mem_rd),
    .i_mem_val (mem_result),
    .i_wb_en   (wb_wb_en),
    .i_wb_rd   (wb_rd),
    .i_wb_val  (wb_result),
    .o_val     (w_fwd_rs2)
  );
`else
  // Producer results are not consumed when forwarding is compiled out.
  logic w_unused_results;
  assign w_unused_results = ^{mem_result, wb_result};
  assign w_fwd_rs1 = r_rs1_val;
  assign w_fwd_rs2 = r_rs2_val;
`endif

  assign ex_valid      = r_valid;
  assign exe_cmd       = r_cmd;
  assign val1          = w_fwd_rs1;
  assign val2          = r_use_imm ? r_imm : w_fwd_rs2;
  assign ex_store_data = w_fwd_rs2;
  assign ex_rd         = r_rd;
  assign ex_mem_read   = r_valid & r_mem_read;
  assign ex_mem_write  = r_valid & r_mem_write;
  assign ex_wb_en      = r_valid & r_wb_en;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios with literal
// expectations, then randomized traffic against an instruction-level model.
// Honours ID_EX_FWD_EN the same way as the design.
module tb_id_ex_stage;
  import exe_pkg::*;

  logic        clk;
  logic        rst, flush, id_valid, id_ready;
  execmd_t     id_exe_cmd, exe_cmd;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd, ex_rd;
  logic [31:0] id_rs1_val, id_rs2_val, id_imm, mem_result, wb_result;
  logic        id_use_imm, id_mem_read, id_mem_write, id_wb_en, mem_wb_en, wb_wb_en;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_wb_en;
  logic [31:0] val1, val2, ex_store_data, stall_cnt;

  int total = 0;
  int bad   = 0;

  id_ex_stage #(.XLEN(32), .RIDX(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_exe_cmd(id_exe_cmd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .id_imm(id_imm),
    .id_use_imm(id_use_imm), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_wb_en(id_wb_en), .mem_wb_en(mem_wb_en), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_wb_en(wb_wb_en), .wb_rd(wb_rd), .wb_result(wb_result), .ex_valid(ex_valid),
    .exe_cmd(exe_cmd), .val1(val1), .val2(val2), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_wb_en(ex_wb_en), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the instruction currently sitting in EX, plus the stall count.
  typedef struct {
    logic        valid;
    logic [3:0]  cmd;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] v1, v2, imm;
    logic        use_imm, mr, mw, wb;
  } instr_t;

  instr_t      m_ex;
  longint      m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Does a write to rd by an enabled producer feed the decode instruction?
  function automatic bit reads_reg(input logic en, input logic [4:0] rd);
    if (!en || rd == 5'd0 || !id_valid) return 1'b0;
    if (id_rs1 == rd) return 1'b1;
    if (id_rs2 == rd && (!id_use_imm || id_mem_write)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit model_hz();
    bit h;
    h = reads_reg(m_ex.valid && m_ex.mr, m_ex.rd);
`ifndef ID_EX_FWD_EN
    h = h || reads_reg(m_ex.valid && m_ex.wb, m_ex.rd)
          || reads_reg(mem_wb_en, mem_rd)
          || reads_reg(wb_wb_en, wb_rd);
`endif
    return h;
  endfunction

  // Newest value of register src visible to EX.
  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] captured);
`ifdef ID_EX_FWD_EN
    if (src != 5'd0 && mem_wb_en && mem_rd == src) return mem_result;
    if (src != 5'd0 && wb_wb_en && wb_rd == src) return wb_result;
`endif
    return captured;
  endfunction

  task automatic model_check();
    chk("id_ready", 32'(id_ready), 32'(!model_hz()));
    chk("stall_cnt", stall_cnt, 32'(m_cnt));
    chk("ex_valid", 32'(ex_valid), 32'(m_ex.valid));
    if (m_ex.valid) begin
      chk("exe_cmd", 32'(exe_cmd), 32'(m_ex.cmd));
      chk("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
      chk("val1", val1, operand(m_ex.rs1, m_ex.v1));
      chk("val2", val2, m_ex.use_imm ? m_ex.imm : operand(m_ex.rs2, m_ex.v2));
      chk("store_data", ex_store_data, operand(m_ex.rs2, m_ex.v2));
      chk("ctrl", {29'd0, ex_mem_read, ex_mem_write, ex_wb_en}, {29'd0, m_ex.mr, m_ex.mw, m_ex.wb});
    end else begin
      chk("ctrl_idle", {29'd0, ex_mem_read, ex_mem_write, ex_wb_en}, 32'd0);
    end
  endtask

  task automatic model_step();
    bit hz;
    hz = model_hz();
    if (rst) begin
      m_ex = '{valid: 1'b0, cmd: 4'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, v1: 32'd0,
               v2: 32'd0, imm: 32'd0, use_imm: 1'b0, mr: 1'b0, mw: 1'b0, wb: 1'b0};
      m_cnt = 0;
    end else if (hz) begin
      m_ex.valid = 1'b0;
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end else begin
      m_ex = '{valid: id_valid && !flush, cmd: id_exe_cmd, rs1: id_rs1, rs2: id_rs2,
               rd: id_rd, v1: id_rs1_val, v2: id_rs2_val, imm: id_imm,
               use_imm: id_use_imm, mr: id_mem_read, mw: id_mem_write, wb: id_wb_en};
    end
  endtask

  // Caller has already driven inputs and let them settle.
  task automatic cycle();
    model_check();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    flush = 1'b0; id_valid = 1'b0; id_exe_cmd = ADD;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_rs1_val = 32'd0; id_rs2_val = 32'd0; id_imm = 32'd0;
    id_use_imm = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0; id_wb_en = 1'b0;
    mem_wb_en = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
    wb_wb_en = 1'b0; wb_rd = 5'd0; wb_result = 32'd0;
  endtask

  task automatic drive_load(input logic [4:0] rd);
    idle_inputs();
    id_valid = 1'b1; id_mem_read = 1'b1; id_wb_en = 1'b1; id_rd = rd;
    id_rs1 = 5'd1; id_use_imm = 1'b1;
  endtask

  logic [31:0] exp_aa, exp_bb;

  initial begin
    m_ex = '{valid: 1'b0, cmd: 4'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, v1: 32'd0,
             v2: 32'd0, imm: 32'd0, use_imm: 1'b0, mr: 1'b0, mw: 1'b0, wb: 1'b0};
    m_cnt = 0;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    #1; cycle();
    #1; cycle();
    rst = 1'b0;

    // Reset state
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_exe_cmd", 32'(exe_cmd), 32'd0);
    chk("rst_val1", val1, 32'd0);
    chk("rst_val2", val2, 32'd0);
    chk("rst_store", ex_store_data, 32'd0);
    chk("rst_ex_rd", 32'(ex_rd), 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_id_ready", 32'(id_ready), 32'd1);

    // Plain pass-through
    id_valid = 1'b1; id_exe_cmd = ADD; id_rs1 = 5'd1; id_rs1_val = 32'd5;
    id_imm = 32'd7; id_use_imm = 1'b1;
    #1; cycle();
    idle_inputs();
    #1;
    chk("pt_val1", val1, 32'd5);
    chk("pt_val2", val2, 32'd7);
    chk("pt_ex_valid", 32'(ex_valid), 32'd1);
    cycle();

    // Forwarding priority
`ifdef ID_EX_FWD_EN
    exp_aa = 32'hAA; exp_bb = 32'hBB;
`else
    exp_aa = 32'h11; exp_bb = 32'h11;
`endif
    id_valid = 1'b1; id_exe_cmd = SUB; id_rs1 = 5'd3; id_rs1_val = 32'h11;
    id_rs2_val = 32'h22; id_rd = 5'd5; id_wb_en = 1'b1;
    #1; cycle();
    idle_inputs();
    mem_wb_en = 1'b1; mem_rd = 5'd3; mem_result = 32'hAA;
    wb_wb_en = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
    #1;
    chk("fwd_mem_prio", val1, exp_aa);
    mem_wb_en = 1'b0;
    #1;
    chk("fwd_wb", val1, exp_bb);
    cycle();
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd0; id_rs1_val = 32'h33; id_use_imm = 1'b1;
    #1; cycle();
    idle_inputs();
    mem_wb_en = 1'b1; mem_rd = 5'd0; mem_result = 32'hAA;
    #1;
    chk("fwd_x0", val1, 32'h33);
    cycle();

    // Load-use: one bubble, then issue
    drive_load(5'd4);
    #1; cycle();
    idle_inputs();
    id_valid = 1'b1; id_exe_cmd = XOR; id_rs1 = 5'd2; id_rs2 = 5'd4; id_rd = 5'd6;
    id_rs1_val = 32'd9; id_rs2_val = 32'h44; id_wb_en = 1'b1;
    #1;
    chk("lu_ready_low", 32'(id_ready), 32'd0);
    cycle();
    #1;
    chk("lu_bubble", 32'(ex_valid), 32'd0);
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    chk("lu_ready_back", 32'(id_ready), 32'd1);
    cycle();
    idle_inputs();
    #1;
    chk("lu_issue_valid", 32'(ex_valid), 32'd1);
    chk("lu_issue_val1", val1, 32'd9);
    chk("lu_issue_val2", val2, 32'h44);
    chk("lu_issue_cmd", 32'(exe_cmd), 32'd5);

    // Flush while hazard is pending
    drive_load(5'd4);
    #1; cycle();
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd4; id_use_imm = 1'b1; flush = 1'b1;
    #1;
    chk("fl_ready_low", 32'(id_ready), 32'd0);
    cycle();
    idle_inputs();
    #1;
    chk("fl_bubble", 32'(ex_valid), 32'd0);
    chk("fl_stall_cnt", stall_cnt, 32'd2);

    // Reset in the middle of a stall
    drive_load(5'd4);
    #1; cycle();
    idle_inputs();
    id_valid = 1'b1; id_rs1 = 5'd4; id_use_imm = 1'b1;
    #1;
    chk("rs_ready_low", 32'(id_ready), 32'd0);
    rst = 1'b1;
    #1; cycle();
    rst = 1'b0;
    #1;
    chk("rs_stall_cnt", stall_cnt, 32'd0);
    chk("rs_ex_valid", 32'(ex_valid), 32'd0);
    chk("rs_id_ready", 32'(id_ready), 32'd1);
    cycle();

    // Randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      id_valid     = ($urandom_range(0, 9) < 8);
      id_exe_cmd   = execmd_t'($urandom_range(0, 9));
      id_rs1       = 5'($urandom_range(0, 4));
      id_rs2       = 5'($urandom_range(0, 4));
      id_rd        = 5'($urandom_range(0, 4));
      id_rs1_val   = $urandom;
      id_rs2_val   = $urandom;
      id_imm       = $urandom;
      id_use_imm   = 1'($urandom_range(0, 1));
      id_mem_read  = ($urandom_range(0, 9) < 3);
      id_mem_write = ($urandom_range(0, 9) < 2);
      id_wb_en     = 1'($urandom_range(0, 1));
      mem_wb_en    = 1'($urandom_range(0, 1));
      mem_rd       = 5'($urandom_range(0, 4));
      mem_result   = $urandom;
      wb_wb_en     = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 4));
      wb_result    = $urandom;
      #1; cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
